// File: rtl/strait_pkg.sv
// Shared definitions for the activation feed path: feeder FSM encoding and
// lane packing constants common to the array, memory and feeder.
package strait_pkg;

    localparam int SYSTOLIC_SIZE_DEF    = 8;
    localparam int ACTIVATION_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        FEED_IDLE  = 2'd0,
        FEED_RUN   = 2'd1,
        FEED_DRAIN = 2'd2
    } feed_state_e;

    // Bit offset of a lane inside a packed row word.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/activation_skew_feeder_if.sv
// Bus between activation memory / controller and the skew feeder.
// SKEW_FEEDER_STALL_EN adds the stall input to the bus.
interface activation_skew_feeder_if
    import strait_pkg::*;
#(
    parameter int SYSTOLIC_SIZE    = SYSTOLIC_SIZE_DEF,
    parameter int ACTIVATION_WIDTH = ACTIVATION_WIDTH_DEF,
    parameter int ADDR_WIDTH       = $clog2(SYSTOLIC_SIZE)
);
    logic                                       start;
    logic [ADDR_WIDTH:0]                        num_rows;
    logic [ADDR_WIDTH-1:0]                      rd_addr;
    logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]  mem_rdata;
    logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]  act_out;
    logic [SYSTOLIC_SIZE-1:0]                   act_valid;
    logic                                       busy;
    logic                                       done;
`ifdef SKEW_FEEDER_STALL_EN
    logic                                       stall;

    modport master (
        output start, num_rows, mem_rdata, stall,
        input  rd_addr, act_out, act_valid, busy, done
    );
    modport slave (
        input  start, num_rows, mem_rdata, stall,
        output rd_addr, act_out, act_valid, busy, done
    );
`else
    modport master (
        output start, num_rows, mem_rdata,
        input  rd_addr, act_out, act_valid, busy, done
    );
    modport slave (
        input  start, num_rows, mem_rdata,
        output rd_addr, act_out, act_valid, busy, done
    );
`endif
endinterface

// File: rtl/activation_skew_feeder_delay.sv
// Per-lane shift register carrying data and valid, with synchronous clear
// and a hold enable; output is the last stage.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             vin,
    output logic [WIDTH-1:0] dout,
    output logic             vout
);
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
        end else if (en) begin
            data_q[0]  <= din;
            valid_q[0] <= vin;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    assign dout = data_q[DEPTH-1];
    assign vout = valid_q[DEPTH-1];

endmodule

// File: rtl/activation_skew_feeder.sv
// Reads activation rows and presents them to the array edge with diagonal skew.
// Optional SKEW_FEEDER_STALL_EN: stall input freezes the whole pass.
//
// state      | meaning
// FEED_IDLE  | waiting for start; N=0 requests only pulse done
// FEED_RUN   | one memory row per cycle, rd_addr 0..N-1
// FEED_DRAIN | zeros shifted through the skew, ends with the done cycle
module activation_skew_feeder
    import strait_pkg::*;
#(
    parameter int SYSTOLIC_SIZE    = SYSTOLIC_SIZE_DEF,
    parameter int ACTIVATION_WIDTH = ACTIVATION_WIDTH_DEF,
    parameter int ADDR_WIDTH       = $clog2(SYSTOLIC_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    activation_skew_feeder_if.slave   bus
);
    localparam int              CW     = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   SIZE_N = CW'(SYSTOLIC_SIZE);

    feed_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]  last_q, last_d;
    logic [CW-1:0]          drain_q, drain_d;
    logic                   zero_done_q, zero_done_d;
    logic [CW-1:0]          n_clamped;
    logic                   feed_valid;
    logic                   done_c;
    logic                   stall_hold;
    logic [SYSTOLIC_SIZE-1:0] lane_valid;

`ifdef SKEW_FEEDER_STALL_EN
    assign stall_hold = bus.stall && (state_q != FEED_IDLE);
`else
    assign stall_hold = 1'b0;
`endif

    assign n_clamped = (bus.num_rows > SIZE_N) ? SIZE_N : bus.num_rows;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        last_d      = last_q;
        drain_d     = drain_q;
        zero_done_d = 1'b0;
        feed_valid  = 1'b0;
        done_c      = zero_done_q;
        case (state_q)
            FEED_IDLE: begin
                // The cycle carrying an N=0 done pulse does not accept a new start.
                if (bus.start && !zero_done_q) begin
                    if (n_clamped == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d   = FEED_RUN;
                        rd_addr_d = '0;
                        last_d    = ADDR_WIDTH'(n_clamped - CW'(1));
                    end
                end
            end
            FEED_RUN: begin
                feed_valid = 1'b1;
                if (rd_addr_q == last_q) begin
                    state_d = FEED_DRAIN;
                    drain_d = SIZE_N;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                end
            end
            FEED_DRAIN: begin
                // Terminal count lands one cycle after the deepest lane's last valid.
                if (drain_q == '0) begin
                    done_c  = 1'b1;
                    state_d = FEED_IDLE;
                end else begin
                    drain_d = drain_q - CW'(1);
                end
            end
            default: state_d = FEED_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FEED_IDLE;
            rd_addr_q   <= '0;
            last_q      <= '0;
            drain_q     <= '0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= zero_done_d;
            if (!stall_hold) begin
                state_q   <= state_d;
                rd_addr_q <= rd_addr_d;
                last_q    <= last_d;
                drain_q   <= drain_d;
            end
        end
    end

    for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_lane
        localparam int LSB = lane_lsb(i, ACTIVATION_WIDTH);
        logic [ACTIVATION_WIDTH-1:0] lane_in;

        assign lane_in = feed_valid ? bus.mem_rdata[LSB +: ACTIVATION_WIDTH] : '0;

        skew_delay_line #(
            .DEPTH (i + 1),
            .WIDTH (ACTIVATION_WIDTH)
        ) u_delay (
            .clk  (clk),
            .clr  (rst),
            .en   (!stall_hold),
            .din  (lane_in),
            .vin  (feed_valid),
            .dout (bus.act_out[LSB +: ACTIVATION_WIDTH]),
            .vout (lane_valid[i])
        );
    end

    assign bus.act_valid = stall_hold ? '0 : lane_valid;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.busy      = (state_q != FEED_IDLE);
    assign bus.done      = done_c && !stall_hold;

endmodule
